// File: rtl/pipe_shifter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pipe_shifter                                                 |
// | Description : Pipelined N-bit shifter/rotator with valid/ready handshakes. |
// |               Performs ROL, SLL, ROR, SRL, SRA and bit-reverse (BTR). The  |
// |               log2(N) binary shift steps are distributed over C registered |
// |               stages; stage k applies a 2^k step when count bit k is set.  |
// | Ports       : clk, rst_n     - clock, synchronous active-low reset          |
// |               in_valid/ready - request handshake                           |
// |               in_data/cnt/op - operand, amount, operation select           |
// |               in_tag         - opaque tag returned with the result         |
// |               flush          - drop every in-flight operation              |
// |               out_valid/ready- result handshake                            |
// |               out_data/tag   - result and its tag                          |
// |               out_err        - operation select was illegal                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pipe_shifter #(
  parameter int N    = 16,
  parameter int C    = 4,
  parameter int TAGW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    in_data,
  input  logic [C-1:0]    in_cnt,
  input  logic [2:0]      in_op,
  input  logic [TAGW-1:0] in_tag,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    out_data,
  output logic [TAGW-1:0] out_tag,
  output logic            out_err
);

  localparam logic [2:0] c_OP_ROL = 3'b000;
  localparam logic [2:0] c_OP_SLL = 3'b001;
  localparam logic [2:0] c_OP_ROR = 3'b010;
  localparam logic [2:0] c_OP_SRL = 3'b011;
  localparam logic [2:0] c_OP_SRA = 3'b100;
  localparam logic [2:0] c_OP_BTR = 3'b101;

  // Stage registers. The full count travels with the operation; stage k only
  // looks at bit k of it.
  logic [N-1:0]    r_data [C];
  logic [C-1:0]    r_cnt  [C];
  logic [2:0]      r_op   [C];
  logic [TAGW-1:0] r_tag  [C];
  logic [C-1:0]    r_err;
  logic [C-1:0]    r_valid;

  // Combinational next value of each stage's data register.
  logic [N-1:0]    w_data [C];
  logic            w_stall;
  logic            w_advance;
  logic            w_unused;

  // Shift/rotate d by a fixed amount sh according to op. BTR and the illegal
  // encodings fall through unchanged.
  function automatic logic [N-1:0] shift_by(input logic [N-1:0] d,
                                            input logic [2:0]   op,
                                            input int           sh);
    logic [N-1:0]        res;
    logic signed [N-1:0] sd;
    sd  = d;
    res = d;
    case (op)
      c_OP_ROL: res = (d << sh) | (d >> (N - sh));
      c_OP_SLL: res = d << sh;
      c_OP_ROR: res = (d >> sh) | (d << (N - sh));
      c_OP_SRL: res = d >> sh;
      c_OP_SRA: res = sd >>> sh;
      default:  res = d;
    endcase
    return res;
  endfunction

  function automatic logic [N-1:0] bit_reverse(input logic [N-1:0] d);
    logic [N-1:0] res;
    res = '0;
    for (int i = 0; i < N; i++) begin
      res[i] = d[N-1-i];
    end
    return res;
  endfunction

  // One pipeline step: stage k contributes a shift of 2^k when enabled.
  function automatic logic [N-1:0] stage_step(input logic [N-1:0] d,
                                              input logic [2:0]   op,
                                              input logic         en,
                                              input int           k);
    logic [N-1:0] res;
    res = d;
    if (en) begin
      res = shift_by(d, op, 1 << k);
    end
    return res;
  endfunction

  // The whole pipeline moves together; only a held result blocks it.
  assign w_stall   = r_valid[C-1] & ~out_ready;
  assign w_advance = ~w_stall;
  assign in_ready  = ~w_stall & ~flush;

  assign out_valid = r_valid[C-1];
  assign out_data  = r_data[C-1];
  assign out_tag   = r_tag[C-1];
  assign out_err   = r_err[C-1];

  // Count and op of the final stage are not needed past the last step.
  assign w_unused  = ^{r_cnt[C-1], r_op[C-1]};

  always_comb begin
    logic [N-1:0] stage0_in;
    // Bit-reverse happens once, at the entry of the first stage; later
    // stages see BTR as a pass-through op.
    stage0_in = (in_op == c_OP_BTR) ? bit_reverse(in_data) : in_data;
    w_data[0] = stage_step(stage0_in, in_op, in_cnt[0], 0);
    for (int k = 1; k < C; k++) begin
      w_data[k] = stage_step(r_data[k-1], r_op[k-1], r_cnt[k-1][k], k);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_err   <= '0;
      for (int k = 0; k < C; k++) begin
        r_data[k] <= '0;
        r_cnt[k]  <= '0;
        r_op[k]   <= '0;
        r_tag[k]  <= '0;
      end
    end else if (flush) begin
      // Flush wins over stall: in-flight work is discarded, payloads kept.
      r_valid <= '0;
    end else if (w_advance) begin
      // Bubbles advance like real operations, so order is preserved.
      r_valid   <= {r_valid[C-2:0], in_valid};
      r_err     <= {r_err[C-2:0], in_op[2] & in_op[1]};
      r_data[0] <= w_data[0];
      r_cnt[0]  <= in_cnt;
      r_op[0]   <= in_op;
      r_tag[0]  <= in_tag;
      for (int k = 1; k < C; k++) begin
        r_data[k] <= w_data[k];
        r_cnt[k]  <= r_cnt[k-1];
        r_op[k]   <= r_op[k-1];
        r_tag[k]  <= r_tag[k-1];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_shifter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pipe_shifter                                              |
// | Description : Self-checking bench for pipe_shifter (N=16).                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pipe_shifter;

  localparam int N    = 16;
  localparam int C    = 4;
  localparam int TAGW = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [N-1:0]    in_data;
  logic [C-1:0]    in_cnt;
  logic [2:0]      in_op;
  logic [TAGW-1:0] in_tag;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [N-1:0]    out_data;
  logic [TAGW-1:0] out_tag;
  logic            out_err;

  always #5 clk = ~clk;

  pipe_shifter #(.N(N), .C(C), .TAGW(TAGW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_cnt    (in_cnt),
    .in_op     (in_op),
    .in_tag    (in_tag),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_err   (out_err)
  );

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference: each result bit is picked directly from the source bit the
  // operation names. Returns {err, data}.
  function automatic logic [N:0] model(input logic [N-1:0] d, input logic [C-1:0] c,
                                       input logic [2:0] op);
    logic [N-1:0] r;
    int s;
    s = int'(c);
    r = '0;
    for (int i = 0; i < N; i++) begin
      case (op)
        3'd0: r[(i + s) % N] = d[i];
        3'd1: if (i >= s) r[i] = d[i - s];
        3'd2: r[i] = d[(i + s) % N];
        3'd3: if (i + s < N) r[i] = d[i + s];
        3'd4: r[i] = (i + s < N) ? d[i + s] : d[N-1];
        3'd5: r[i] = d[N-1-i];
        default: r[i] = d[i];
      endcase
    end
    return {op[2] & op[1], r};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after the acceptance edge; counts edges including it.
  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
  endtask

  typedef struct {
    logic [2:0]      op;
    logic [N-1:0]    d;
    logic [C-1:0]    c;
    logic [TAGW-1:0] tag;
    logic [N-1:0]    exp_d;
    logic            exp_err;
  } vec_t;

  vec_t vecs[8];
  logic [TAGW-1:0] exp_q[$];
  logic [N:0]      exp_r[$];

  initial begin
    int lat;
    int emitted;
    int ready_low;
    int hold;
    bit seen;
    int idx;
    logic [N-1:0]    held_d;
    logic [TAGW-1:0] held_t;
    int got[$];
    logic [N:0] m;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_cnt = '0; in_op = '0;
    in_tag = '0; flush = 1'b0; out_ready = 1'b1;

    // ---------------- reset state ----------------
    step(); step();
    rst_n = 1'b1;
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_data",  64'(out_data),  64'd0);
    check("reset_out_tag",   64'(out_tag),   64'd0);
    check("reset_out_err",   64'(out_err),   64'd0);
    check("reset_in_ready",  64'(in_ready),  64'd1);
    step();

    // ---------------- directed vectors ----------------
    vecs[0] = '{3'b000, 16'h8001, 4'd1,  4'h1, 16'h0003, 1'b0};
    vecs[1] = '{3'b100, 16'h8000, 4'd15, 4'h2, 16'hFFFF, 1'b0};
    vecs[2] = '{3'b011, 16'h8000, 4'd15, 4'h3, 16'h0001, 1'b0};
    vecs[3] = '{3'b001, 16'h00F0, 4'd4,  4'h4, 16'h0F00, 1'b0};
    vecs[4] = '{3'b010, 16'h0001, 4'd1,  4'h5, 16'h8000, 1'b0};
    vecs[5] = '{3'b101, 16'h0001, 4'd7,  4'hA, 16'h8000, 1'b0};
    vecs[6] = '{3'b111, 16'h1234, 4'd5,  4'hA, 16'h1234, 1'b1};
    vecs[7] = '{3'b100, 16'h8421, 4'd0,  4'h7, 16'h8421, 1'b0};

    for (int v = 0; v < 8; v++) begin
      in_valid = 1'b1; in_op = vecs[v].op; in_data = vecs[v].d;
      in_cnt = vecs[v].c; in_tag = vecs[v].tag;
      step();
      in_valid = 1'b0;
      wait_out(lat);
      check($sformatf("vec%0d_latency", v), 64'(lat), 64'(C));
      check($sformatf("vec%0d_result", v), {43'd0, out_err, out_tag, out_data},
            {43'd0, vecs[v].exp_err, vecs[v].tag, vecs[v].exp_d});
      step();
    end
    repeat (3) step();

    // ---------------- backpressure ----------------
    idx = 0; hold = 0; seen = 0; ready_low = 0;
    held_d = '0; held_t = '0;
    for (int cyc = 0; cyc < 40 && got.size() < 6; cyc++) begin
      if (out_valid && !seen) begin
        seen = 1; hold = 3; held_d = out_data; held_t = out_tag;
      end
      out_ready = (hold == 0);
      in_valid  = (idx < 6);
      in_data   = 16'h0101 << idx;
      in_cnt    = 4'(idx);
      in_op     = 3'b000;
      in_tag    = 4'(idx);
      @(negedge clk);
      if (hold > 0)
        check("bp_hold_stable", {44'd0, out_tag, out_data}, {44'd0, held_t, held_d});
      if (!in_ready) ready_low++;
      if (out_valid && out_ready) begin
        got.push_back(int'(out_tag));
        m = model(16'h0101 << out_tag, 4'(out_tag), 3'b000);
        check("bp_data", {47'd0, out_err, out_data}, {47'd0, m});
      end
      if (in_valid && in_ready) idx++;
      if (hold > 0) hold--;
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("bp_in_ready_low_cycles", 64'(ready_low), 64'd3);
    check("bp_result_count", 64'(got.size()), 64'd6);
    for (int i = 0; i < got.size(); i++)
      check($sformatf("bp_order%0d", i), 64'(got[i]), 64'(i));
    repeat (6) step();

    // ---------------- reset mid-stream ----------------
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_op = 3'b001; in_data = 16'h0F0F; in_cnt = 4'(i); in_tag = 4'(i + 8);
      step();
    end
    in_valid = 1'b0; rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    check("rst_mid_out_valid", 64'(out_valid), 64'd0);
    check("rst_mid_out_data",  64'(out_data),  64'd0);
    emitted = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_valid) emitted++;
    end
    check("rst_mid_no_emit", 64'(emitted), 64'd0);
    in_valid = 1'b1; in_op = 3'b010; in_data = 16'h00C3; in_cnt = 4'd3; in_tag = 4'h6;
    step();
    in_valid = 1'b0;
    wait_out(lat);
    m = model(16'h00C3, 4'd3, 3'b010);
    check("rst_after_latency", 64'(lat), 64'(C));
    check("rst_after_result", {43'd0, out_err, out_tag, out_data}, {43'd0, m[N], 4'h6, m[N-1:0]});
    step(); step();

    // ---------------- flush ----------------
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_op = 3'b000; in_data = 16'h1111; in_cnt = 4'(i); in_tag = 4'(i + 1);
      step();
    end
    flush = 1'b1; in_tag = 4'hF; in_data = 16'hDEAD;
    #1;
    check("flush_in_ready", 64'(in_ready), 64'd0);
    step();
    flush = 1'b0;
    check("flush_cleared", 64'(out_valid), 64'd0);
    in_valid = 1'b1; in_op = 3'b011; in_data = 16'hF00F; in_cnt = 4'd2; in_tag = 4'h9;
    step();
    in_valid = 1'b0;
    wait_out(lat);
    m = model(16'hF00F, 4'd2, 3'b011);
    check("flush_next_latency", 64'(lat), 64'(C));
    check("flush_next_result", {43'd0, out_err, out_tag, out_data}, {43'd0, m[N], 4'h9, m[N-1:0]});
    step(); step();

    // ---------------- randomized against scoreboard ----------------
    exp_q.delete(); exp_r.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 31) == 0);
      in_op     = 3'($urandom_range(0, 7));
      in_data   = 16'($urandom);
      in_cnt    = 4'($urandom);
      in_tag    = 4'($urandom);
      @(negedge clk);
      check("rnd_in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready) && !flush));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("rnd_unexpected_result", 64'd1, 64'd0);
        end else begin
          check("rnd_result", {43'd0, out_err, out_tag, out_data},
                {43'd0, exp_r[0][N], exp_q[0], exp_r[0][N-1:0]});
          void'(exp_q.pop_front());
          void'(exp_r.pop_front());
        end
      end
      if (flush) begin
        exp_q.delete(); exp_r.delete();
      end else if (in_valid && in_ready) begin
        exp_q.push_back(in_tag);
        exp_r.push_back(model(in_data, in_cnt, in_op));
      end
      step();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
      @(negedge clk);
      if (out_valid) begin
        check("drain_result", {43'd0, out_err, out_tag, out_data},
              {43'd0, exp_r[0][N], exp_q[0], exp_r[0][N-1:0]});
        void'(exp_q.pop_front());
        void'(exp_r.pop_front());
      end
      step();
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_shifter.md
# pipe_shifter

Parametrised, pipelined successor to the 16-bit combinational barrel shifter. It performs rotate, logical shift, arithmetic shift and bit-reverse on an N-bit operand. The log2(N) shift stages are split across registered pipeline stages, with valid/ready handshakes on both sides. It sits between the execute-stage operand muxes and the writeback path, and is intended for wide or multi-cycle shift units where the combinational shifter limits timing.

## Interface
- N, 16: operand width; power of two, 8..64.
- C, 4: count width; must equal log2(N).
- TAGW, 4: width of the opaque tag passed alongside each operation.
- clk  in  1  clock; all state changes on posedge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  block can accept a request this cycle.
- in_data  in  N  operand.
- in_cnt  in  C  shift/rotate amount.
- in_op  in  3  operation select.
- in_tag  in  TAGW  opaque tag, returned unchanged.
- flush  in  1  discard all in-flight operations.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_data  out  N  result.
- out_tag  out  TAGW  tag of the result.
- out_err  out  1  the op was illegal.

## Operation
- Op encoding:
  - 000: ROL.
  - 001: SLL (zero fill).
  - 010: ROR.
  - 011: SRL (zero fill).
  - 100: SRA (fill with in_data[N-1]).
  - 101: BTR, out[i] = in[N-1-i]; in_cnt is ignored.
  - 110, 111: illegal. out_data = in_data and out_err = 1.
- Count is taken modulo N by width. Count 0 returns in_data unchanged for every shift/rotate op.
- Pipeline has C stages. Stage k (k = 0..C-1) conditionally shifts or rotates by 2^k according to in_cnt[k].
- Each stage ends in a register carrying data, the remaining count bits, op, tag, err and valid.
- BTR and illegal ops pass through all stages unmodified in value, except that BTR reverses the bits at stage 0.
- The pipeline advances only as a whole:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall.
  - A transfer occurs when in_valid & in_ready, or out_valid & out_ready.
- Bubbles are not compressed. Results leave in strict acceptance order.
- flush clears every stage valid bit on the next edge.
  - in_ready is 0 in the flush cycle.
  - A request presented in that cycle is not accepted.
  - flush has priority over stall.

## Timing
- Reset (rst_n low at posedge) clears all stage valids, out_valid, out_data, out_tag and out_err to 0. in_ready is 1 from the first cycle after reset.
- Reset mid-operation drops all in-flight operations. None are emitted afterwards.
- Latency: a request accepted at edge t gives out_valid = 1 after edge t+C-1, i.e. visible in cycle t+C, when there is no stall. Default N=16 gives 4 cycles.
- Throughput: one operation per cycle while out_ready = 1.
- While stalled:
  - out_data, out_tag and out_err hold stable.
  - All stage registers hold.
  - in_ready = 0.
- Simultaneous out_valid & out_ready and in_valid: the result retires and the new request enters stage 0 on the same edge.
- out_valid stays high until accepted. It never drops without out_ready, except on reset or flush.

## Test plan
- ROL, N=16: in_data=16'h8001, in_cnt=1, out_ready=1. Requires out_data=16'h0003 with out_valid exactly 4 cycles after acceptance and out_err=0.
- SRA vs SRL: in_data=16'h8000, in_cnt=15. SRA gives 16'hFFFF and SRL gives 16'h0001. SLL of 16'h00F0 by 4 gives 16'h0F00. ROR of 16'h0001 by 1 gives 16'h8000.
- BTR and illegal ops:
  - BTR in_data=16'h0001, in_cnt=7 gives 16'h8000.
  - in_op=111, in_data=16'h1234 gives 16'h1234 with out_err=1.
  - tag 4'hA is returned on both.
- Backpressure: 6 back-to-back requests with tags 0..5; out_ready held low for 3 cycles after the first out_valid. Requires:
  - in_ready low during exactly those 3 cycles.
  - out_data and out_tag stable throughout.
  - All 6 results in tag order, with none lost or duplicated.
- Reset mid-stream: 3 operations in flight, rst_n low for one edge. The next cycle has out_valid=0 and out_data=0, and no result is ever emitted for those operations. A request after reset completes in 4 cycles.
- Flush: 4 operations in flight plus in_valid asserted with flush. Requires:
  - in_ready=0 in that cycle.
  - All stage valids clear after the edge.
  - A request issued the following cycle emerges 4 cycles later as the next result.
